// File: rtl/signature_dumper.sv
// Signature dumper: after the test ends (tohost store or idle timeout), reads
// the signature region word by word and streams it out over a valid/ready port.
module signature_dumper #(
  parameter logic [15:0] TOHOST_ADDR = 16'hFFF0,
  parameter logic [15:0] SIG_BEGIN   = 16'h0000,
  parameter logic [15:0] SIG_END     = 16'h1000,
  parameter logic [31:0] TIMEOUT     = 32'd200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        sig_valid,
  output logic [31:0] sig_data,
  input  logic        sig_ready,
  output logic        done,
  output logic        pass,
  output logic        timed_out
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    HOLD,
    DONE
  } state_t;

  // Address of the final signature word; the walk stops here without wrapping.
  localparam logic [15:0] LAST_ADDR = 16'(SIG_END - 16'd4);
  localparam bit          EMPTY     = (SIG_BEGIN == SIG_END);

  state_t      state;
  logic [31:0] idle_cnt;
  logic        tohost_hit;
  logic        timeout_hit;

  // Trigger sources; a tohost store wins over a coincident timeout.
  assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
  assign timeout_hit = (TIMEOUT != 32'd0) && (idle_cnt == 32'(TIMEOUT - 32'd1));

  // Dump sequencer; rd_addr doubles as the word pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= SIG_BEGIN;
      sig_valid <= 1'b0;
      sig_data  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tohost_hit || timeout_hit) begin
            pass      <= tohost_hit && (mem_wdata == 32'd1);
            timed_out <= !tohost_hit;
            rd_addr   <= SIG_BEGIN;
            if (EMPTY) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              rd_en <= 1'b1;
            end
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        READ: begin
          rd_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          sig_data  <= rd_data;
          sig_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (sig_ready) begin
            sig_valid <= 1'b0;
            if (rd_addr == LAST_ADDR) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              rd_addr <= rd_addr + 16'd4;
              rd_en   <= 1'b1;
              state   <= READ;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signature_dumper.sv
// Bench for signature_dumper: a cycle-level behavioural model of the dump
// sequence checked every cycle, directed scenarios with literal expectations,
// and randomized runs. A second instance exercises the empty-region case.
module tb_signature_dumper;

  localparam logic [15:0] TOHOST = 16'hFFF0;
  localparam int          NWORDS = 4;
  localparam int          TMO    = 50;
  localparam logic [15:0] E_ADDR = 16'h0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        sig_ready = 1'b0;
  logic [31:0] rd_data;

  logic        rd_en, sig_valid, done, pass, timed_out;
  logic [15:0] rd_addr;
  logic [31:0] sig_data;
  logic        rd_en_e, sig_valid_e, done_e, pass_e, timed_out_e;
  logic [15:0] rd_addr_e;
  logic [31:0] sig_data_e;

  signature_dumper #(
    .TOHOST_ADDR(TOHOST), .SIG_BEGIN(16'h0000), .SIG_END(16'h0010), .TIMEOUT(32'd50)
  ) dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sig_valid(sig_valid), .sig_data(sig_data), .sig_ready(sig_ready),
    .done(done), .pass(pass), .timed_out(timed_out)
  );

  signature_dumper #(
    .TOHOST_ADDR(TOHOST), .SIG_BEGIN(E_ADDR), .SIG_END(E_ADDR), .TIMEOUT(32'd0)
  ) dut_e (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_en(rd_en_e), .rd_addr(rd_addr_e), .rd_data(rd_data),
    .sig_valid(sig_valid_e), .sig_data(sig_data_e), .sig_ready(sig_ready),
    .done(done_e), .pass(pass_e), .timed_out(timed_out_e)
  );

  always #5 clk = ~clk;

  // Synchronous data memory for the 4-word signature region.
  logic [31:0] ram [4];
  always @(posedge clk) begin
    if (rd_en && rd_addr < 16'h0010) rd_data <= ram[rd_addr[3:2]];
    if (mem_we && mem_addr < 16'h0010) ram[mem_addr[3:2]] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model state: phase 0 idle, 1 dumping, 2 done; ev is the edge that launched
  // the current word's read (trigger or previous handshake).
  int          phase = 0, ev = 0, nacc = 0, idle_cnt = 0, rd_pulses = 0;
  bit          started = 0, m_pass = 0, m_to = 0, e_done = 0, e_pass = 0;
  logic [31:0] acc_log[$];

  // Compare DUT outputs with the model, then advance the model over the coming edge.
  always @(negedge clk) begin
    bit exp_rd, exp_v;
    int exp_addr;
    if (started) begin
      exp_rd   = (phase == 1) && (cyc == ev);
      exp_v    = (phase == 1) && (cyc >= ev + 2);
      exp_addr = (phase == 0) ? 0 : (phase == 1) ? 4 * nacc : 4 * (NWORDS - 1);
      check("rd_en", 32'(rd_en), 32'(exp_rd));
      check("sig_valid", 32'(sig_valid), 32'(exp_v));
      check("rd_addr", 32'(rd_addr), 32'(exp_addr));
      if (exp_v) check("sig_data", sig_data, ram[nacc]);
      if (phase == 0) check("sig_data_idle", sig_data, 32'd0);
      check("done", 32'(done), 32'(phase == 2));
      check("pass", 32'(pass), 32'(m_pass));
      check("timed_out", 32'(timed_out), 32'(m_to));
      check("e_rd_en", 32'(rd_en_e), 32'd0);
      check("e_sig_valid", 32'(sig_valid_e), 32'd0);
      check("e_rd_addr", 32'(rd_addr_e), 32'(E_ADDR));
      check("e_sig_data", sig_data_e, 32'd0);
      check("e_done", 32'(done_e), 32'(e_done));
      check("e_pass", 32'(pass_e), 32'(e_pass));
      check("e_timed_out", 32'(timed_out_e), 32'd0);
      if (sig_valid && sig_ready) acc_log.push_back(sig_data);
      if (rd_en) rd_pulses++;
    end
    if (reset) begin
      started = 1; phase = 0; idle_cnt = 0; nacc = 0; ev = 0;
      m_pass = 0; m_to = 0; e_done = 0; e_pass = 0;
      acc_log.delete(); rd_pulses = 0;
    end else begin
      if (phase == 0) begin
        if (mem_we && mem_addr == TOHOST) begin
          phase = 1; ev = cyc + 1; nacc = 0; m_pass = (mem_wdata == 32'd1); m_to = 0;
        end else begin
          idle_cnt++;
          if (idle_cnt == TMO) begin
            phase = 1; ev = cyc + 1; nacc = 0; m_pass = 0; m_to = 1;
          end
        end
      end else if (phase == 1) begin
        if (cyc >= ev + 2 && sig_ready) begin
          nacc++;
          if (nacc == NWORDS) phase = 2;
          else ev = cyc + 1;
        end
      end
      if (!e_done && mem_we && mem_addr == TOHOST) begin
        e_done = 1; e_pass = (mem_wdata == 32'd1);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; mem_we = 1'b0; sig_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    @(posedge clk); #1;
    mem_we = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    while (!done && i < bound) begin @(posedge clk); #1; i++; end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_word(input int n);
    int i = 0;
    while (!(acc_log.size() == n && sig_valid) && i < 100) begin @(posedge clk); #1; i++; end
    check("word_reached", 32'(acc_log.size() == n && sig_valid), 32'd1);
  endtask

  task automatic check_log(input string name, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] exp [4];
    exp = '{w0, w1, w2, w3};
    check({name, "_count"}, 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) check(name, acc_log[i], exp[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] hold;

    // Reset state and basic dump with pass code 1.
    do_reset();
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_sig_valid", 32'(sig_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_sig_data", sig_data, 32'd0);
    sig_ready = 1'b1;
    store(16'h0000, 32'h11); store(16'h0004, 32'h22);
    store(16'h0008, 32'h33); store(16'h000C, 32'h44);
    store(TOHOST, 32'd1);
    check("empty_done_one_edge", 32'(done_e), 32'd1);
    k = 1;
    while (!sig_valid && k < 10) begin @(posedge clk); #1; k++; end
    check("first_valid_edge", 32'(k), 32'd3);
    wait_done(40);
    check_log("dump_pass", 32'h11, 32'h22, 32'h33, 32'h44);
    check("dump_pass_pass", 32'(pass), 32'd1);
    check("dump_pass_to", 32'(timed_out), 32'd0);
    check("dump_pass_rd", 32'(rd_pulses), 32'd4);
    store(TOHOST, 32'd5);
    repeat (2) begin @(posedge clk); #1; end
    check("late_tohost_pass", 32'(pass), 32'd1);
    check("late_tohost_e_pass", 32'(pass_e), 32'd1);
    check("late_tohost_e_done", 32'(done_e), 32'd1);

    // Failing tohost code.
    do_reset();
    sig_ready = 1'b1;
    store(TOHOST, 32'd5);
    wait_done(40);
    check_log("dump_fail", 32'h11, 32'h22, 32'h33, 32'h44);
    check("dump_fail_pass", 32'(pass), 32'd0);
    check("dump_fail_to", 32'(timed_out), 32'd0);

    // Backpressure on word 2.
    do_reset();
    sig_ready = 1'b1;
    store(16'h0000, 32'hA0); store(16'h0004, 32'hA1);
    store(16'h0008, 32'hA2); store(16'h000C, 32'hA3);
    store(TOHOST, 32'd1);
    wait_word(1);
    sig_ready = 1'b0;
    hold = sig_data;
    check("stall_word2", hold, 32'hA1);
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_data", sig_data, 32'hA1);
      check("stall_valid", 32'(sig_valid), 32'd1);
      check("stall_rd_en", 32'(rd_en), 32'd0);
    end
    sig_ready = 1'b1;
    wait_done(40);
    check_log("stall_log", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    check("stall_rd_pulses", 32'(rd_pulses), 32'd4);

    // Timeout with no tohost store.
    do_reset();
    sig_ready = 1'b1;
    k = 0;
    while (!rd_en && k < 100) begin @(posedge clk); #1; k++; end
    check("timeout_edges", 32'(k), 32'd50);
    check("timeout_flag", 32'(timed_out), 32'd1);
    check("timeout_pass", 32'(pass), 32'd0);
    wait_done(40);
    check_log("timeout_log", 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Reset while word 3 is held, then restart.
    do_reset();
    sig_ready = 1'b1;
    store(TOHOST, 32'd1);
    wait_word(2);
    sig_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_valid", 32'(sig_valid), 32'd0);
    check("midrst_data", sig_data, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    check("midrst_addr", 32'(rd_addr), 32'd0);
    sig_ready = 1'b1;
    store(TOHOST, 32'd1);
    check("restart_rd_en", 32'(rd_en), 32'd1);
    check("restart_addr", 32'(rd_addr), 32'd0);
    wait_done(40);
    check_log("restart_log", 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Randomized runs; the per-cycle model does the checking.
    for (int r = 0; r < 40; r++) begin
      bit use_to, mid;
      int ns, rpt, gap;
      logic [15:0] a;
      do_reset();
      sig_ready = 1'($urandom_range(0, 1));
      ns = $urandom_range(0, 6);
      for (int s = 0; s < ns; s++) begin
        a = ($urandom_range(0, 4) == 4) ? 16'h0200 : 16'(4 * $urandom_range(0, 3));
        store(a, $urandom);
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
      end
      use_to = ($urandom_range(0, 3) == 0);
      if (!use_to) store(TOHOST, ($urandom_range(0, 1) != 0) ? 32'd1 : $urandom);
      mid = ($urandom_range(0, 4) == 0);
      rpt = $urandom_range(1, 10);
      for (int c = 0; c < 400 && !done; c++) begin
        sig_ready = ($urandom_range(0, 2) != 0);
        if (!use_to && $urandom_range(0, 7) == 0) begin
          mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = $urandom;
        end else begin
          mem_we = 1'b0;
        end
        if (mid && c == rpt) begin
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0; mem_we = 1'b0;
          break;
        end
        @(posedge clk); #1;
      end
      mem_we = 1'b0;
      if (!mid) check("run_done", 32'(done), 32'd1);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
